layer_priority_mux: RTL and testbench
=====================================

LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

Interface
REQ-001 Parameter NUM_LAYERS, default 16: number of drawable layers; layer 0 has highest priority.
REQ-002 Parameter RGB_W, default 8: colour width per layer and output.
REQ-003 Parameter TRANSPARENT, default 8'hFF (RGB_W bits): colour-key value treated as "no pixel".
REQ-004 Parameter BLINK_FRAMES, default 16: frames per blink half-period; legal range 1..255.
REQ-005 clk  in  1  pixel clock.
REQ-006 resetN  in  1  reset, asynchronous, active-low.
REQ-007 layer_req  in  NUM_LAYERS  per-layer drawing request; bit i belongs to layer i.
REQ-008 layer_rgb  in  NUM_LAYERS*RGB_W  packed layer colours; layer i occupies bits [i*RGB_W +: RGB_W].
REQ-009 bg_rgb  in  RGB_W  background colour (MIF), used when no layer is visible.
REQ-010 idle  in  1  game idle; forces background for the pixel sampled in that cycle.
REQ-011 start_of_frame  in  1  one-cycle pulse per frame; drives the blink counter.
REQ-012 cfg_we  in  1  configuration write strobe.
REQ-013 cfg_idx  in  clog2(NUM_LAYERS)  target layer of the write.
REQ-014 cfg_en  in  1  new enable bit for the layer.
REQ-015 cfg_blink  in  1  new blink bit for the layer.
REQ-016 rgb_out  out  RGB_W  composited pixel.
REQ-017 hit_valid  out  1  a layer won for this pixel.
REQ-018 hit_idx  out  clog2(NUM_LAYERS)  index of the winning layer; 0 when hit_valid=0.

Function
REQ-019 Layer i SHALL be visible iff layer_req[i]=1, en[i]=1, colour != TRANSPARENT, and NOT (blink[i]=1 AND phase=1).
REQ-020 Stage 1 SHALL register the visibility vector, all layer colours, bg_rgb and idle at every clock edge.
REQ-021 Stage 2 SHALL register the output: if stage-1 idle=1 -> bg colour, hit_valid=0; else lowest-index visible layer colour, hit_valid=1, hit_idx=index; else bg colour, hit_valid=0.
REQ-022 Latency SHALL be exactly 2 cycles from input sample to rgb_out, fully pipelined, one pixel per clock, no stalls.
REQ-023 A cfg_we write SHALL update en[cfg_idx] and blink[cfg_idx] at the clock edge; a pixel sampled in the same cycle SHALL use the old values.
REQ-024 cfg_idx >= NUM_LAYERS SHALL be ignored with no state change.
REQ-025 Blink counter (8 bits) SHALL increment on each start_of_frame; on start_of_frame with counter = BLINK_FRAMES-1 it SHALL wrap to 0 and toggle phase.
REQ-026 Phase SHALL be sampled into stage 1 with the pixel; a phase toggle SHALL affect pixels sampled from the next cycle on.
REQ-027 Simultaneous visible layers SHALL resolve strictly by index; a transparent-coloured higher layer SHALL fall through to the next layer, not to background.
REQ-028 start_of_frame held high for k cycles SHALL count as k frames (no edge detection).

Reset
REQ-029 On resetN=0, asynchronously: rgb_out=0, hit_valid=0, hit_idx=0, all pipeline registers 0, counter=0, phase=0, en=all ones, blink=all zeros.
REQ-030 Reset mid-frame SHALL discard in-flight pixels; first valid output SHALL appear 2 cycles after the first post-reset sampling edge.

Verification
REQ-031 Reset, then layer_req=0, bg_rgb=8'h25 -> rgb_out=8'h25, hit_valid=0 two cycles later.
REQ-032 layer_req[3]=layer_req[7]=1, colours 8'h1C/8'hE0 -> rgb_out=8'h1C, hit_idx=3; set layer 3 colour=8'hFF -> rgb_out=8'hE0, hit_idx=7.
REQ-033 cfg_we, cfg_idx=3, cfg_en=0, pixel in same cycle with layer 3 visible -> that pixel outputs layer 3; next pixel outputs layer 7.
REQ-034 blink[5]=1, BLINK_FRAMES=2, only layer 5 requesting -> layer 5 shown after 0-1 frame pulses, background after 2-3, shown again after 4.
REQ-035 idle=1 with layer 0 visible -> background, hit_valid=0; resetN pulsed mid-stream -> outputs 0 immediately, en all ones afterwards.

Source files
------------

// File: rtl/layer_priority_mux.sv
// Two-stage priority compositor for stacked sprite/overlay layers.
// Lowest index wins; per-layer enable and blink state, frame-driven blink phase.
module layer_priority_mux #(
    parameter int NUM_LAYERS = 16,
    parameter int RGB_W = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = {RGB_W{1'b1}},
    parameter int BLINK_FRAMES = 16,
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic [NUM_LAYERS-1:0]       layer_req,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic                        idle,
    input  logic                        start_of_frame,
    input  logic                        cfg_we,
    input  logic [IDX_W-1:0]            cfg_idx,
    input  logic                        cfg_en,
    input  logic                        cfg_blink,
    output logic [RGB_W-1:0]            rgb_out,
    output logic                        hit_valid,
    output logic [IDX_W-1:0]            hit_idx
);

    localparam logic [7:0] CNT_LAST = 8'(BLINK_FRAMES - 1);

    logic [NUM_LAYERS-1:0]       en;
    logic [NUM_LAYERS-1:0]       blink;
    logic [7:0]                  blink_cnt;
    logic                        phase;

    logic [NUM_LAYERS-1:0]       vis;
    logic [NUM_LAYERS-1:0]       vis_q;
    logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0]            bg_q;
    logic                        idle_q;

    logic                        sel_found;
    logic [IDX_W-1:0]            sel_idx;
    logic [RGB_W-1:0]            sel_rgb;

    always_comb begin
        vis = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            vis[i] = layer_req[i] & en[i]
                   & (layer_rgb[i*RGB_W +: RGB_W] != TRANSPARENT)
                   & ~(blink[i] & phase);
        end
    end

    // Writes to indices beyond the layer count are dropped.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            en    <= '1;
            blink <= '0;
        end else if (cfg_we && (int'(cfg_idx) < NUM_LAYERS)) begin
            en[cfg_idx]    <= cfg_en;
            blink[cfg_idx] <= cfg_blink;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (start_of_frame) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vis_q  <= '0;
            rgb_q  <= '0;
            bg_q   <= '0;
            idle_q <= 1'b0;
        end else begin
            vis_q  <= vis;
            rgb_q  <= layer_rgb;
            bg_q   <= bg_rgb;
            idle_q <= idle;
        end
    end

    // Scan high to low so the lowest visible index is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rgb   = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (vis_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rgb   = rgb_q[i*RGB_W +: RGB_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_out   <= '0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
        end else if (idle_q || !sel_found) begin
            rgb_out   <= bg_q;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
        end else begin
            rgb_out   <= sel_rgb;
            hit_valid <= 1'b1;
            hit_idx   <= sel_idx;
        end
    end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Bench for layer_priority_mux: directed scenarios plus random traffic
// against a frame-counting reference model.
module tb_layer_priority_mux;

    localparam int NL = 12;
    localparam int BF = 2;

    typedef struct {
        logic [7:0] rgb;
        logic       hv;
        logic [3:0] idx;
    } exp_t;

    logic          clk;
    logic          resetN;
    logic [NL-1:0] layer_req;
    logic [NL*8-1:0] layer_rgb;
    logic [7:0]    bg_rgb;
    logic          idle;
    logic          sof;
    logic          cfg_we;
    logic [3:0]    cfg_idx;
    logic          cfg_en;
    logic          cfg_blink;
    logic [7:0]    rgb_out;
    logic          hit_valid;
    logic [3:0]    hit_idx;

    int   checks;
    int   failures;

    bit   en_m[NL];
    bit   blink_m[NL];
    int   frames;
    exp_t pipe0;
    exp_t pipe1;

    layer_priority_mux #(
        .NUM_LAYERS(NL),
        .RGB_W(8),
        .TRANSPARENT(8'hFF),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .layer_req(layer_req),
        .layer_rgb(layer_rgb),
        .bg_rgb(bg_rgb),
        .idle(idle),
        .start_of_frame(sof),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_en(cfg_en),
        .cfg_blink(cfg_blink),
        .rgb_out(rgb_out),
        .hit_valid(hit_valid),
        .hit_idx(hit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_pix();
        exp_t e;
        bit   ph;
        e.rgb = bg_rgb;
        e.hv  = 1'b0;
        e.idx = 4'd0;
        ph = ((frames / BF) % 2) == 1;
        if (!idle) begin
            for (int i = 0; i < NL; i++) begin
                if (!e.hv && layer_req[i] && en_m[i]
                    && layer_rgb[i*8 +: 8] != 8'hFF
                    && !(blink_m[i] && ph)) begin
                    e.rgb = layer_rgb[i*8 +: 8];
                    e.hv  = 1'b1;
                    e.idx = 4'(i);
                end
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            en_m[i]    = 1'b1;
            blink_m[i] = 1'b0;
        end
        frames = 0;
        pipe0 = '{8'h00, 1'b0, 4'd0};
        pipe1 = '{8'h00, 1'b0, 4'd0};
    endtask

    task automatic tick();
        exp_t e;
        e = model_pix();
        @(posedge clk);
        if (cfg_we && int'(cfg_idx) < NL) begin
            en_m[cfg_idx]    = cfg_en;
            blink_m[cfg_idx] = cfg_blink;
        end
        if (sof) frames++;
        pipe1 = pipe0;
        pipe0 = e;
        #1;
    endtask

    task automatic set_col(input int i, input logic [7:0] c);
        layer_rgb[i*8 +: 8] = c;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        layer_req = '1;
        layer_rgb = '0;
        bg_rgb = 8'h5A;
        idle = 1'b0;
        sof = 1'b0;
        cfg_we = 1'b0;
        cfg_idx = '0;
        cfg_en = 1'b0;
        cfg_blink = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: got rgb=%h hv=%b idx=%0d want 00/0/0",
                     rgb_out, hit_valid, hit_idx);
        end
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_background();
        layer_req = '0;
        bg_rgb = 8'h25;
        tick();
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== {8'h25, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL background: got rgb=%h hv=%b idx=%0d want 25/0/0",
                     rgb_out, hit_valid, hit_idx);
        end
    endtask

    task automatic test_priority();
        layer_rgb = '0;
        layer_req = '0;
        layer_req[3] = 1'b1;
        layer_req[7] = 1'b1;
        set_col(3, 8'h1C);
        set_col(7, 8'hE0);
        tick();
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== {8'h1C, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL priority_l3: got rgb=%h hv=%b idx=%0d want 1c/1/3",
                     rgb_out, hit_valid, hit_idx);
        end
        set_col(3, 8'hFF);
        tick();
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== {8'hE0, 1'b1, 4'd7}) begin
            failures++;
            $display("FAIL fallthrough_l7: got rgb=%h hv=%b idx=%0d want e0/1/7",
                     rgb_out, hit_valid, hit_idx);
        end
        set_col(3, 8'h1C);
    endtask

    task automatic test_cfg_same_cycle();
        tick();
        tick();
        cfg_we = 1'b1;
        cfg_idx = 4'd3;
        cfg_en = 1'b0;
        cfg_blink = 1'b0;
        tick();
        cfg_we = 1'b0;
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== {8'h1C, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL cfg_old_value: got rgb=%h hv=%b idx=%0d want 1c/1/3",
                     rgb_out, hit_valid, hit_idx);
        end
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== {8'hE0, 1'b1, 4'd7}) begin
            failures++;
            $display("FAIL cfg_new_value: got rgb=%h hv=%b idx=%0d want e0/1/7",
                     rgb_out, hit_valid, hit_idx);
        end
        cfg_we = 1'b1;
        cfg_en = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_blink();
        bit shown[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [12:0] want;
        layer_req = '0;
        layer_req[5] = 1'b1;
        set_col(5, 8'h5A);
        cfg_we = 1'b1;
        cfg_idx = 4'd5;
        cfg_en = 1'b1;
        cfg_blink = 1'b1;
        tick();
        cfg_we = 1'b0;
        for (int p = 0; p < 5; p++) begin
            tick();
            tick();
            want = shown[p] ? {8'h5A, 1'b1, 4'd5} : {8'h25, 1'b0, 4'd0};
            checks++;
            if ({rgb_out, hit_valid, hit_idx} !== want) begin
                failures++;
                $display("FAIL blink_after_%0d_frames: got %h/%b/%0d want %h/%b/%0d",
                         p, rgb_out, hit_valid, hit_idx,
                         want[12:5], want[4], want[3:0]);
            end
            sof = 1'b1;
            tick();
            sof = 1'b0;
        end
        cfg_we = 1'b1;
        cfg_blink = 1'b0;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_idle();
        layer_req = '0;
        layer_req[0] = 1'b1;
        set_col(0, 8'h33);
        idle = 1'b1;
        tick();
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== {8'h25, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL idle_forces_bg: got rgb=%h hv=%b idx=%0d want 25/0/0",
                     rgb_out, hit_valid, hit_idx);
        end
        idle = 1'b0;
        tick();
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== {8'h33, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL idle_release: got rgb=%h hv=%b idx=%0d want 33/1/0",
                     rgb_out, hit_valid, hit_idx);
        end
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            layer_req = NL'($urandom);
            for (int i = 0; i < NL; i++)
                set_col(i, ($urandom % 4 == 0) ? 8'hFF : 8'($urandom));
            bg_rgb = 8'($urandom);
            idle = ($urandom % 10) == 0;
            sof = ($urandom % 3) == 0;
            cfg_we = ($urandom % 6) == 0;
            cfg_idx = 4'($urandom);
            cfg_en = ($urandom % 5) != 0;
            cfg_blink = ($urandom % 3) == 0;
            tick();
            checks++;
            if (rgb_out !== pipe1.rgb || hit_valid !== pipe1.hv
                || hit_idx !== pipe1.idx) begin
                failures++;
                $display("FAIL random_pixel_%0d: got %h/%b/%0d want %h/%b/%0d",
                         c, rgb_out, hit_valid, hit_idx,
                         pipe1.rgb, pipe1.hv, pipe1.idx);
            end
        end
        cfg_we = 1'b0;
        sof = 1'b0;
        idle = 1'b0;
    endtask

    task automatic test_reset_mid();
        layer_req = '1;
        for (int i = 0; i < NL; i++) set_col(i, 8'h40 + 8'(i));
        cfg_we = 1'b1;
        cfg_idx = 4'd0;
        cfg_en = 1'b0;
        tick();
        cfg_we = 1'b0;
        tick();
        resetN = 1'b0;
        #1;
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: got rgb=%h hv=%b idx=%0d want 00/0/0",
                     rgb_out, hit_valid, hit_idx);
        end
        #1;
        resetN = 1'b1;
        model_reset();
        tick();
        checks++;
        if ({rgb_out, hit_valid, hit_idx} !== 13'd0) begin
            failures++;
            $display("FAIL reset_flush: got rgb=%h hv=%b idx=%0d want 00/0/0",
                     rgb_out, hit_valid, hit_idx);
        end
        for (int k = 0; k < NL; k++) begin
            layer_req = '0;
            layer_req[k] = 1'b1;
            tick();
            tick();
            checks++;
            if ({rgb_out, hit_valid, hit_idx} !== {8'h40 + 8'(k), 1'b1, 4'(k)}) begin
                failures++;
                $display("FAIL en_after_reset_l%0d: got rgb=%h hv=%b idx=%0d",
                         k, rgb_out, hit_valid, hit_idx);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_background();
        test_priority();
        test_cfg_same_cycle();
        test_blink();
        test_idle();
        test_random(400);
        test_reset_mid();
        test_random(200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
